// File: rtl/pwm_fade_scheduler.sv
// Eight-channel LED PWM scheduler: one shared period counter, per-channel duty/target/step, one round-robin fade engine.
// Latency: a jump command shows on pwm_out_o one frame boundary after acceptance; a fade's first step shows one frame later.
// Backpressure: cmd_ready_o drops for the 8-cycle fade walk at the start of each frame; a held command waits and is never dropped.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   cmd_valid_i/_ready_o command handshake (accepted when both high)
//   cmd_chan_i          channel to update
//   cmd_target_i        requested duty in clocks, clamped to the period P
//   cmd_step_i          fade increment per frame; 0 jumps straight to the target
//   pwm_out_o           registered PWM, one bit per channel
//   busy_o              channel duty has not yet reached its target
//   frame_tick_o        high on the last clock of every frame
// The period P = CLK_FREQ/PWM_FREQ must lie in 16..65535 so the walk fits in one frame.

module pwm_fade_scheduler #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned PWM_FREQ = 1250,
  parameter int unsigned N        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [2:0]    cmd_chan_i,
  input  logic [15:0]   cmd_target_i,
  input  logic [7:0]    cmd_step_i,
  output logic [N-1:0]  pwm_out_o,
  output logic [N-1:0]  busy_o,
  output logic          frame_tick_o
);

  localparam int unsigned P      = CLK_FREQ / PWM_FREQ;
  localparam logic [15:0] P_W    = 16'(P);
  localparam logic [15:0] LAST_W = 16'(P - 1);

  typedef enum logic {IDLE, UPDATE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;

  // duty_q is the working value the fade engine moves; cmp_q is the shadow
  // the comparator uses, refreshed only at frame ends so a frame never glitches.
  logic [15:0] duty_q   [N];
  logic [15:0] duty_d   [N];
  logic [15:0] cmp_q    [N];
  logic [15:0] cmp_d    [N];
  logic [15:0] target_q [N];
  logic [15:0] target_d [N];
  logic [7:0]  step_q   [N];
  logic [7:0]  step_d   [N];
  logic [N-1:0] pwm_q, pwm_d;

  logic        frame_tick;
  logic        accept;
  logic [15:0] tgt_clamped;

  // Fade arithmetic is done one bit wider so duty + step cannot wrap.
  logic [16:0] f_cur, f_tgt, f_stp, f_sum, f_dif;
  logic [15:0] fade_nxt;

  assign frame_tick   = (cnt_q == LAST_W);
  assign frame_tick_o = frame_tick;
  assign cmd_ready_o  = (state_q == IDLE);
  assign accept       = cmd_valid_i && cmd_ready_o;
  assign tgt_clamped  = (cmd_target_i > P_W) ? P_W : cmd_target_i;
  assign pwm_out_o    = pwm_q;

  // Period counter
  always_comb begin
    cnt_d = frame_tick ? 16'd0 : cnt_q + 16'd1;
  end

  // Fade walk FSM: one channel per cycle, starting the cycle after frame_tick
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = 3'd0;
        end
      end
      UPDATE: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Next duty for the channel under the walk; never overshoots the target.
  always_comb begin
    f_cur    = {1'b0, duty_q[idx_q]};
    f_tgt    = {1'b0, target_q[idx_q]};
    f_stp    = {9'd0, step_q[idx_q]};
    f_sum    = f_cur + f_stp;
    f_dif    = f_cur - f_tgt;
    fade_nxt = duty_q[idx_q];
    if (f_cur < f_tgt) begin
      fade_nxt = (f_sum >= f_tgt) ? target_q[idx_q] : f_sum[15:0];
    end else if (f_cur > f_tgt) begin
      fade_nxt = (f_dif <= f_stp) ? target_q[idx_q] : (duty_q[idx_q] - {8'd0, step_q[idx_q]});
    end
  end

  // Channel state. Commands are only accepted in IDLE, so a command write
  // and a walk write can never hit the same cycle.
  always_comb begin
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    if (accept) begin
      target_d[cmd_chan_i] = tgt_clamped;
      step_d[cmd_chan_i]   = cmd_step_i;
      if (cmd_step_i == 8'd0) begin
        duty_d[cmd_chan_i] = tgt_clamped;
      end
    end
    if (state_q == UPDATE) begin
      duty_d[idx_q] = fade_nxt;
    end
  end

  // Shadow load, compare and busy
  always_comb begin
    cmp_d  = cmp_q;
    pwm_d  = '0;
    busy_o = '0;
    for (int i = 0; i < N; i++) begin
      if (frame_tick) begin
        cmp_d[i] = duty_q[i];
      end
      pwm_d[i]  = (cnt_q < cmp_q[i]);
      busy_o[i] = (duty_q[i] != target_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 16'd0;
      pwm_q   <= '0;
      for (int i = 0; i < N; i++) begin
        duty_q[i]   <= 16'd0;
        cmp_q[i]    <= 16'd0;
        target_q[i] <= 16'd0;
        step_q[i]   <= 8'd0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      duty_q   <= duty_d;
      cmp_q    <= cmp_d;
      target_q <= target_d;
      step_q   <= step_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Bench for pwm_fade_scheduler at P = 20: commands drive a queue of expected per-frame high counts.
// A negedge monitor counts pwm_out high cycles over each output frame and compares against the queue.
// Handshake stalls, busy flags, clamping and reset behaviour are checked directly from the stimulus.

module tb_pwm_fade_scheduler;

  localparam int P = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_chan;
  logic [15:0] cmd_target;
  logic [7:0]  cmd_step;
  logic [7:0]  pwm_out;
  logic [7:0]  busy;
  logic        frame_tick;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int frame;
    int ch;
    int hi;
  } exp_t;

  exp_t sb[$];
  int   acc[8];
  int   tcount = 0;
  bit   tick_d = 1'b0;

  pwm_fade_scheduler #(
    .CLK_FREQ(20000),
    .PWM_FREQ(1000),
    .N(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_chan_i  (cmd_chan),
    .cmd_target_i(cmd_target),
    .cmd_step_i  (cmd_step),
    .pwm_out_o   (pwm_out),
    .busy_o      (busy),
    .frame_tick_o(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Output frame t holds the shadow loaded at frame_tick number t-1; it spans
  // from the cycle after tick t-1 plus one (pwm lags cnt) to the cycle after tick t.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) acc[i] = 0;
      tick_d = 1'b0;
      tcount = 0;
    end else begin
      for (int i = 0; i < 8; i++) acc[i] += int'(pwm_out[i]);
      if (tick_d) begin
        while (sb.size() != 0 && sb[0].frame <= tcount) begin
          e = sb.pop_front();
          if (e.frame < tcount) begin
            check_eq($sformatf("sb_missed_c%0d", e.ch), e.frame, tcount);
          end else begin
            check_eq($sformatf("hi_f%0d_c%0d", e.frame, e.ch), acc[e.ch], e.hi);
          end
        end
        for (int i = 0; i < 8; i++) acc[i] = 0;
      end
      tick_d = frame_tick;
      if (frame_tick) tcount++;
    end
  end

  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int f, input int ch, input int hi);
    exp_t e;
    e.frame = f;
    e.ch    = ch;
    e.hi    = hi;
    sb.push_back(e);
  endtask

  task automatic wait_tick_cnt(input int t);
    int n = 0;
    while (tcount < t && n < 50 * P) begin
      step_clk();
      n++;
    end
    check_eq("wait_tick_cnt", 32'(tcount >= t), 1);
  endtask

  task automatic wait_frame_tick();
    int n = 0;
    while (!frame_tick && n < 4 * P) begin
      step_clk();
      n++;
    end
    check_eq("tick_seen", frame_tick, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50 * P) begin
      step_clk();
      n++;
    end
    check_eq("drain", sb.size(), 0);
    repeat (10) step_clk();
  endtask

  // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
  task automatic send_cmd(input logic [2:0] ch, input logic [15:0] tgt, input logic [7:0] stp,
                          output int acc_t, output int stalls);
    cmd_valid  = 1'b1;
    cmd_chan   = ch;
    cmd_target = tgt;
    cmd_step   = stp;
    stalls     = 0;
    while (!cmd_ready && stalls < 100) begin
      step_clk();
      stalls++;
    end
    check_eq("cmd_ready", cmd_ready, 1);
    acc_t = tcount;
    step_clk();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int j, k, st, n;
    int up [8];
    int dn [5];
    int hs [6];
    up = '{3, 6, 9, 12, 15, 18, 20, 20};
    dn = '{20, 13, 6, 1, 1};
    hs = '{0, 2, 4, 6, 7, 7};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_chan   = 3'd0;
    cmd_target = 16'd0;
    cmd_step   = 8'd0;
    repeat (3) step_clk();

    // Reset state
    check_eq("rst_pwm", pwm_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tick", frame_tick, 0);
    check_eq("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    n = 0;
    while (!frame_tick && n < 200) begin
      step_clk();
      n++;
    end
    check_eq("first_tick", n, P - 1);
    repeat (10) step_clk();

    // Jump: ch3 to 5, other channels stay dark
    send_cmd(3'd3, 16'd5, 8'd0, j, st);
    check_eq("jump_busy", busy, 0);
    for (int f = j + 2; f <= j + 3; f++)
      for (int c = 0; c < 8; c++) push(f, c, (c == 3) ? 5 : 0);
    drain();
    check_eq("jump_busy_end", busy, 0);

    // Fade up: ch0 to 20 by 3
    send_cmd(3'd0, 16'd20, 8'd3, j, st);
    check_eq("up_busy", busy[0], 1);
    push(j + 2, 0, 0);
    for (int i = 0; i < 8; i++) push(j + 3 + i, 0, up[i]);
    drain();
    check_eq("up_busy_end", busy[0], 0);

    // Fade down: ch0 from 20 to 1 by 7, no undershoot
    send_cmd(3'd0, 16'd1, 8'd7, j, st);
    check_eq("dn_busy", busy[0], 1);
    for (int i = 0; i < 5; i++) push(j + 2 + i, 0, dn[i]);
    drain();
    check_eq("dn_busy_end", busy[0], 0);

    // Handshake: command presented on the first walk cycle waits 8 cycles
    wait_frame_tick();
    step_clk();
    send_cmd(3'd2, 16'd7, 8'd2, j, st);
    check_eq("hs_stall", st, 8);
    push(j + 2, 3, 5);
    for (int i = 0; i < 6; i++) push(j + 2 + i, 2, hs[i]);
    drain();
    check_eq("hs_busy_end", busy[2], 0);

    // Command accepted on the frame_tick cycle joins the very next walk
    wait_frame_tick();
    send_cmd(3'd4, 16'd9, 8'd4, j, st);
    check_eq("tick_stall", st, 0);
    push(j + 2, 4, 4);
    push(j + 3, 4, 8);
    push(j + 4, 4, 9);
    push(j + 5, 4, 9);
    drain();

    // Override mid-fade: ch5 rising by 2, then retargeted down to 4
    send_cmd(3'd5, 16'd50, 8'd2, j, st);
    push(j + 2, 5, 0);
    push(j + 3, 5, 2);
    push(j + 4, 5, 4);
    push(j + 5, 5, 6);
    wait_tick_cnt(j + 3);
    repeat (10) step_clk();
    send_cmd(3'd5, 16'd4, 8'd3, k, st);
    check_eq("ovr_frame", k, j + 3);
    push(j + 6, 5, 4);
    push(j + 7, 5, 4);
    drain();
    check_eq("ovr_busy_end", busy[5], 0);

    // Clamp: target 50 is stored as 20, so the fade settles in two steps
    send_cmd(3'd6, 16'd50, 8'd15, j, st);
    push(j + 2, 6, 0);
    push(j + 3, 6, 15);
    push(j + 4, 6, 20);
    push(j + 5, 6, 20);
    drain();
    check_eq("clamp_busy_all", busy, 0);

    // Reset in the middle of a slow fade
    send_cmd(3'd1, 16'd20, 8'd1, j, st);
    wait_tick_cnt(j + 3);
    repeat (5) step_clk();
    check_eq("mid_busy", busy[1], 1);
    check_eq("mid_sb_empty", sb.size(), 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_pwm", pwm_out, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_tick", frame_tick, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    repeat (3) step_clk();
    rst_n = 1'b1;
    n = 0;
    while (!frame_tick && n < 200) begin
      step_clk();
      n++;
    end
    check_eq("first_tick2", n, P - 1);
    for (int f = 2; f <= 3; f++)
      for (int c = 0; c < 8; c++) push(f, c, 0);
    drain();
    check_eq("post_rst_busy", busy, 0);

    check_eq("sb_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
